// File: rtl/led_pwm_ctrl_if.sv
// Bus interface for led_pwm_ctrl: ibex-style req/gnt/rvalid data bus.
// Signals:
//   req_i    master -> slave  bus request
//   we_i     master -> slave  1 = write, 0 = read
//   addr_i   master -> slave  byte address within block, bits [3:2] decoded
//   be_i     master -> slave  byte enables for writes
//   wdata_i  master -> slave  write data
//   gnt_o    slave -> master  grant (combinationally equal to req_i)
//   rvalid_o slave -> master  response valid, one cycle after acceptance
//   rdata_o  slave -> master  read data, valid with rvalid_o
interface led_pwm_ctrl_if;
  logic        req_i;
  logic        we_i;
  logic [3:0]  addr_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;

  modport master (
    output req_i, we_i, addr_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, addr_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/led_pwm_ctrl.sv
// LED output controller: memory-mapped static pattern, blinking and 8-bit
// PWM dimming driving the top-level LED pins.
// Ports:
//   clk    system clock
//   srst   synchronous reset, active-high
//   bus    data bus slave (req/gnt/rvalid), see led_pwm_ctrl_if
//   led_o  registered LED drive, NUM_LED bits
// Register map (word offsets):
//   0x0 CTRL     [NUM_LED-1:0] led_val, [8] blink_en
//   0x4 PRESCALE [23:0] blink half-period minus 1
//   0x8 DUTY     [7:0] PWM duty
//   0xC STATUS   read-only: [0] blink phase, [15:8] pwm_cnt
module led_pwm_ctrl #(
  parameter int unsigned NUM_LED      = 4,
  parameter logic [23:0] PRESCALE_RST = 24'd4999999
) (
  input  logic                clk,
  input  logic                srst,
  led_pwm_ctrl_if.slave       bus,
  output logic [NUM_LED-1:0]  led_o
);

  // Merge write data into a 24-bit register, one byte lane per enable bit.
  function automatic logic [23:0] merge_bytes24(input logic [23:0] cur,
                                                input logic [23:0] wd,
                                                input logic [2:0]  be);
    logic [23:0] res;
    res = cur;
    for (int i = 0; i < 3; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = wd[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [NUM_LED-1:0] led_val_r;
  logic               blink_en_r;
  logic [23:0]        prescale_r;
  logic [7:0]         duty_r;
  logic [23:0]        blink_cnt_r;
  logic               phase_r;
  logic [7:0]         pwm_cnt_r;
  logic [NUM_LED-1:0] led_r;
  logic               rvalid_r;
  logic [31:0]        rdata_r;

  logic               wr_s;
  logic               rd_s;
  logic               wr_ctrl_s;
  logic               wr_prescale_s;
  logic               wr_duty_s;
  logic               prescale_touch_s;
  logic [31:0]        rdata_mux_s;
  logic [23:0]        blink_cnt_nxt_s;
  logic               phase_nxt_s;
  logic               pwm_on_s;
  logic               unused_s;

  // Every request is granted in the cycle it is presented.
  assign bus.gnt_o    = bus.req_i;
  assign bus.rvalid_o = rvalid_r;
  assign bus.rdata_o  = rdata_r;
  assign led_o        = led_r;

  assign wr_s          = bus.req_i & bus.we_i;
  assign rd_s          = bus.req_i & ~bus.we_i;
  assign wr_ctrl_s     = wr_s & (bus.addr_i[3:2] == 2'd0);
  assign wr_prescale_s = wr_s & (bus.addr_i[3:2] == 2'd1);
  assign wr_duty_s     = wr_s & (bus.addr_i[3:2] == 2'd2);
  // Only the three implemented PRESCALE lanes count as touching the register.
  assign prescale_touch_s = wr_prescale_s & (|bus.be_i[2:0]);
  assign pwm_on_s         = (pwm_cnt_r < duty_r);

  // Bits with no register behind them.
  assign unused_s = ^{bus.addr_i[1:0], bus.be_i[3], bus.wdata_i[31:24]};

  // Read-data mux: register contents as seen at the accepting edge.
  always_comb begin
    rdata_mux_s = 32'd0;
    case (bus.addr_i[3:2])
      2'd0: begin
        rdata_mux_s[NUM_LED-1:0] = led_val_r;
        rdata_mux_s[8]           = blink_en_r;
      end
      2'd1: rdata_mux_s[23:0] = prescale_r;
      2'd2: rdata_mux_s[7:0]  = duty_r;
      2'd3: begin
        rdata_mux_s[15:8] = pwm_cnt_r;
        rdata_mux_s[0]    = phase_r;
      end
      default: rdata_mux_s = 32'd0;
    endcase
  end

  // Blink engine next state; a PRESCALE write restarts the half-period count
  // so a smaller new value can never leave the counter above it.
  always_comb begin
    blink_cnt_nxt_s = blink_cnt_r;
    phase_nxt_s     = phase_r;
    if (!blink_en_r) begin
      blink_cnt_nxt_s = 24'd0;
      phase_nxt_s     = 1'b1;
    end else if (prescale_touch_s) begin
      blink_cnt_nxt_s = 24'd0;
    end else if (blink_cnt_r == prescale_r) begin
      blink_cnt_nxt_s = 24'd0;
      phase_nxt_s     = ~phase_r;
    end else begin
      blink_cnt_nxt_s = blink_cnt_r + 24'd1;
    end
  end

  // Register file, engines, bus response and LED output.
  always_ff @(posedge clk) begin
    if (srst) begin
      led_val_r   <= '0;
      blink_en_r  <= 1'b0;
      prescale_r  <= PRESCALE_RST;
      duty_r      <= 8'hFF;
      blink_cnt_r <= 24'd0;
      phase_r     <= 1'b1;
      pwm_cnt_r   <= 8'd0;
      led_r       <= '0;
      rvalid_r    <= 1'b0;
      rdata_r     <= 32'd0;
    end else begin
      if (wr_ctrl_s && bus.be_i[0]) begin
        led_val_r <= bus.wdata_i[NUM_LED-1:0];
      end
      if (wr_ctrl_s && bus.be_i[1]) begin
        blink_en_r <= bus.wdata_i[8];
      end
      if (wr_prescale_s) begin
        prescale_r <= merge_bytes24(prescale_r, bus.wdata_i[23:0], bus.be_i[2:0]);
      end
      if (wr_duty_s && bus.be_i[0]) begin
        duty_r <= bus.wdata_i[7:0];
      end
      blink_cnt_r <= blink_cnt_nxt_s;
      phase_r     <= phase_nxt_s;
      // PWM period is 255 cycles so DUTY=255 is continuously on.
      pwm_cnt_r   <= (pwm_cnt_r == 8'd254) ? 8'd0 : (pwm_cnt_r + 8'd1);
      led_r       <= led_val_r & {NUM_LED{phase_r & pwm_on_s}};
      rvalid_r    <= bus.req_i;
      rdata_r     <= rd_s ? rdata_mux_s : 32'd0;
    end
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Self-checking bench for led_pwm_ctrl. Expected LED and STATUS values come
// from closed-form expressions of the elapsed cycle count: pwm_cnt is the
// cycle count modulo 255 and the blink phase flips once per PRESCALE+1
// cycles from the edge at which counting (re)started.
module tb_led_pwm_ctrl;
  localparam int NL = 4;

  logic          clk  = 1'b0;
  logic          srst = 1'b1;
  logic [NL-1:0] led_o;

  led_pwm_ctrl_if bus();

  led_pwm_ctrl #(.NUM_LED(NL), .PRESCALE_RST(24'd4999999)) dut (
    .clk   (clk),
    .srst  (srst),
    .bus   (bus),
    .led_o (led_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // edges since the last reset edge

  always @(posedge clk) cyc <= srst ? 0 : cyc + 1;

  // Reference model configuration
  logic [NL-1:0] m_led_val;
  bit            m_blink_en;
  int            m_prescale;
  int            m_duty;
  int            m_start;    // edge at which blink counting restarted from 0
  bit            m_phase0;   // phase just after m_start
  int            m_off;      // edge at which blink was switched off

  function automatic bit exp_phase(int k);
    if (m_blink_en || k <= m_off)
      return m_phase0 ^ ((((k - m_start) / (m_prescale + 1)) % 2) == 1);
    return 1'b1;
  endfunction

  // LED value registered at edge k+1, from state after edge k.
  function automatic logic [NL-1:0] exp_led(int k);
    bit on;
    on = exp_phase(k) && ((k % 255) < m_duty);
    return m_led_val & {NL{on}};
  endfunction

  function automatic logic [31:0] exp_status(int k);
    return {16'd0, 8'(k % 255), 7'd0, exp_phase(k)};
  endfunction

  task automatic model_reset();
    m_led_val  = '0;
    m_blink_en = 1'b0;
    m_prescale = 4999999;
    m_duty     = 255;
    m_start    = 0;
    m_phase0   = 1'b1;
    m_off      = -1;
  endtask

  task automatic do_reset();
    srst       = 1'b1;
    bus.req_i  = 1'b0;
    repeat (3) @(negedge clk);
    srst = 1'b0;
    model_reset();
  endtask

  // One bus transfer, starting and ending at a falling edge. w is the index
  // of the accepting edge; rv/rd are the response seen in the next cycle.
  task automatic bus_xfer(input bit we, input logic [3:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, output logic rv, output logic [31:0] rd,
                          output int w);
    bus.req_i   = 1'b1;
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.be_i    = be;
    bus.wdata_i = wd;
    @(posedge clk);
    #1 w = cyc;
    @(negedge clk);
    rv = bus.rvalid_o;
    rd = bus.rdata_o;
    bus.req_i = 1'b0;
    bus.we_i  = 1'b0;
    bus.be_i  = 4'd0;
  endtask

  task automatic test_reset();
    logic rv; logic [31:0] rd; int w;
    logic [31:0] exp_rd [3];
    exp_rd = '{32'h0, 32'h004C4B3F, 32'h000000FF};
    do_reset();
    checks++; if (led_o !== 4'h0) begin errors++; $display("FAIL reset_led: got %h expected 0", led_o); end
    checks++; if (bus.rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", bus.rvalid_o); end
    checks++; if (bus.rdata_o !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata_o); end
    checks++; if (bus.gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 0", bus.gnt_o); end
    for (int i = 0; i < 3; i++) begin
      bus_xfer(1'b0, 4'(4 * i), 4'hF, 32'd0, rv, rd, w);
      checks++; if (rv !== 1'b1) begin errors++; $display("FAIL reset_read_rvalid[%0d]: got %b expected 1", i, rv); end
      checks++; if (rd !== exp_rd[i]) begin errors++; $display("FAIL reset_read[%0d]: got %h expected %h", i, rd, exp_rd[i]); end
    end
    bus_xfer(1'b0, 4'hC, 4'hF, 32'd0, rv, rd, w);
    checks++; if (rd !== exp_status(w - 1)) begin errors++; $display("FAIL reset_status: got %h expected %h", rd, exp_status(w - 1)); end
  endtask

  task automatic test_static();
    logic rv; logic [31:0] rd; int w;
    logic [NL-1:0] v;
    for (int i = 0; i < 4; i++) begin
      v = (i == 0) ? 4'h5 : 4'($urandom);
      bus_xfer(1'b1, 4'h0, 4'hF, 32'(v), rv, rd, w);
      m_led_val = v;
      checks++; if (rv !== 1'b1) begin errors++; $display("FAIL static_wr_rvalid: got %b expected 1", rv); end
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL static_wr_rdata: got %h expected 0", rd); end
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        checks++; if (led_o !== exp_led(cyc - 1)) begin errors++; $display("FAIL static_led: got %h expected %h", led_o, exp_led(cyc - 1)); end
      end
      if (i == 0) begin
        checks++; if (led_o !== 4'b0101) begin errors++; $display("FAIL static_led_5: got %b expected 0101", led_o); end
      end
    end
    bus.req_i = 1'b1;
    #1;
    checks++; if (bus.gnt_o !== 1'b1) begin errors++; $display("FAIL gnt_high: got %b expected 1", bus.gnt_o); end
    bus.req_i = 1'b0;
    #1;
    checks++; if (bus.gnt_o !== 1'b0) begin errors++; $display("FAIL gnt_low: got %b expected 0", bus.gnt_o); end
    @(negedge clk);
  endtask

  task automatic test_blink();
    logic rv; logic [31:0] rd; int w;
    int np;
    bit ph;
    bus_xfer(1'b1, 4'h4, 4'hF, 32'd3, rv, rd, w);
    m_prescale = 3;
    bus_xfer(1'b1, 4'h0, 4'hF, 32'h10F, rv, rd, w);
    m_led_val = 4'hF; m_blink_en = 1'b1; m_start = w; m_phase0 = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 24; j++) begin
        bus_xfer(1'b0, 4'hC, 4'hF, 32'd0, rv, rd, w);
        checks++; if (rd !== exp_status(w - 1)) begin errors++; $display("FAIL blink_status: got %h expected %h", rd, exp_status(w - 1)); end
        checks++; if (led_o !== exp_led(w - 1)) begin errors++; $display("FAIL blink_led: got %h expected %h", led_o, exp_led(w - 1)); end
      end
      // Rewrite PRESCALE mid-blink: count restarts, phase is kept.
      np = $urandom_range(0, 5);
      bus_xfer(1'b1, 4'h4, 4'hF, 32'(np), rv, rd, w);
      checks++; if (led_o !== exp_led(w - 1)) begin errors++; $display("FAIL blink_led_pw: got %h expected %h", led_o, exp_led(w - 1)); end
      ph = exp_phase(w - 1);
      m_prescale = np; m_start = w; m_phase0 = ph;
    end
    bus_xfer(1'b1, 4'h0, 4'hF, 32'h00F, rv, rd, w);
    m_off = w; m_blink_en = 1'b0;
    for (int j = 0; j < 6; j++) begin
      bus_xfer(1'b0, 4'hC, 4'hF, 32'd0, rv, rd, w);
      checks++; if (rd !== exp_status(w - 1)) begin errors++; $display("FAIL blink_off_status: got %h expected %h", rd, exp_status(w - 1)); end
      checks++; if (led_o !== exp_led(w - 1)) begin errors++; $display("FAIL blink_off_led: got %h expected %h", led_o, exp_led(w - 1)); end
    end
  endtask

  task automatic test_pwm();
    logic rv; logic [31:0] rd; int w;
    int dl [4];
    int cnt;
    dl = '{64, 0, 255, 0};
    dl[3] = $urandom_range(1, 254);
    bus_xfer(1'b1, 4'h0, 4'hF, 32'h1, rv, rd, w);
    m_led_val = 4'h1;
    for (int i = 0; i < 4; i++) begin
      bus_xfer(1'b1, 4'h8, 4'hF, 32'(dl[i]), rv, rd, w);
      m_duty = dl[i];
      @(negedge clk);
      cnt = 0;
      for (int j = 0; j < 255; j++) begin
        @(negedge clk);
        checks++; if (led_o !== exp_led(cyc - 1)) begin errors++; $display("FAIL pwm_led: got %h expected %h duty %0d", led_o, exp_led(cyc - 1), dl[i]); end
        if (led_o[0]) cnt++;
      end
      checks++; if (cnt != dl[i]) begin errors++; $display("FAIL pwm_on_count: got %0d expected %0d", cnt, dl[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic rv; logic [31:0] rd; int w;
    int d;
    for (int i = 0; i < 8; i++) begin
      d = $urandom_range(0, 255);
      bus_xfer(1'b1, 4'h8, 4'hF, {$urandom} & 32'hFFFF_FF00 | 32'(d), rv, rd, w);
      m_duty = d;
      checks++; if (rv !== 1'b1) begin errors++; $display("FAIL b2b_wr_rvalid: got %b expected 1", rv); end
      bus_xfer(1'b0, 4'h8, 4'hF, 32'd0, rv, rd, w);
      checks++; if (rv !== 1'b1 || rd !== 32'(d)) begin errors++; $display("FAIL b2b_rd_duty: got %b/%h expected 1/%h", rv, rd, 32'(d)); end
    end
    bus_xfer(1'b1, 4'h8, 4'hF, 32'hFF, rv, rd, w);
    m_duty = 255;
  endtask

  task automatic test_byte_enable();
    logic rv; logic [31:0] rd; int w;
    bus_xfer(1'b1, 4'h0, 4'hF, 32'h5, rv, rd, w);
    m_led_val = 4'h5;
    bus_xfer(1'b1, 4'h4, 4'hF, 32'd20, rv, rd, w);
    m_prescale = 20;
    bus_xfer(1'b1, 4'h0, 4'b0010, 32'h0000_01FF, rv, rd, w);
    m_blink_en = 1'b1; m_start = w; m_phase0 = 1'b1;
    bus_xfer(1'b0, 4'h0, 4'hF, 32'd0, rv, rd, w);
    checks++; if (rd !== 32'h105) begin errors++; $display("FAIL be_ctrl_lane1: got %h expected 00000105", rd); end
    bus_xfer(1'b1, 4'hC, 4'hF, 32'hFFFF_FFFF, rv, rd, w);
    checks++; if (rv !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL status_wr_resp: got %b/%h expected 1/0", rv, rd); end
    bus_xfer(1'b0, 4'h5, 4'hF, 32'd0, rv, rd, w);
    checks++; if (rd !== 32'd20) begin errors++; $display("FAIL status_wr_prescale: got %h expected 14", rd); end
    bus_xfer(1'b0, 4'hC, 4'hF, 32'd0, rv, rd, w);
    checks++; if (rd !== exp_status(w - 1)) begin errors++; $display("FAIL status_wr_status: got %h expected %h", rd, exp_status(w - 1)); end
    bus_xfer(1'b1, 4'h4, 4'b0000, 32'h00FF_FFFF, rv, rd, w);
    checks++; if (rv !== 1'b1) begin errors++; $display("FAIL be0_rvalid: got %b expected 1", rv); end
    bus_xfer(1'b0, 4'h4, 4'hF, 32'd0, rv, rd, w);
    checks++; if (rd !== 32'd20) begin errors++; $display("FAIL be0_prescale: got %h expected 14", rd); end
    bus_xfer(1'b1, 4'h0, 4'b0001, 32'hFFFF_FEFA, rv, rd, w);
    m_led_val = 4'hA;
    bus_xfer(1'b0, 4'h0, 4'hF, 32'd0, rv, rd, w);
    checks++; if (rd !== 32'h10A) begin errors++; $display("FAIL be_ctrl_lane0: got %h expected 0000010A", rd); end
    bus_xfer(1'b1, 4'h8, 4'b0010, 32'h0000_3300, rv, rd, w);
    bus_xfer(1'b0, 4'h8, 4'hF, 32'd0, rv, rd, w);
    checks++; if (rd !== 32'hFF) begin errors++; $display("FAIL be_duty_lane1: got %h expected 000000FF", rd); end
    for (int j = 0; j < 30; j++) begin
      bus_xfer(1'b0, 4'hC, 4'hF, 32'd0, rv, rd, w);
      checks++; if (rd !== exp_status(w - 1)) begin errors++; $display("FAIL be_status: got %h expected %h", rd, exp_status(w - 1)); end
      checks++; if (led_o !== exp_led(w - 1)) begin errors++; $display("FAIL be_led: got %h expected %h", led_o, exp_led(w - 1)); end
    end
  endtask

  task automatic test_srst();
    logic rv; logic [31:0] rd; int w;
    // srst together with a read request: no response, everything cleared
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 4'h0; bus.be_i = 4'hF;
    srst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.rvalid_o !== 1'b0) begin errors++; $display("FAIL srst_req_rvalid: got %b expected 0", bus.rvalid_o); end
    checks++; if (led_o !== 4'h0) begin errors++; $display("FAIL srst_req_led: got %h expected 0", led_o); end
    bus.req_i = 1'b0;
    srst = 1'b0;
    model_reset();
    bus_xfer(1'b0, 4'h0, 4'hF, 32'd0, rv, rd, w);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL srst_ctrl: got %h expected 0", rd); end
    bus_xfer(1'b0, 4'h8, 4'hF, 32'd0, rv, rd, w);
    checks++; if (rd !== 32'hFF) begin errors++; $display("FAIL srst_duty: got %h expected FF", rd); end
    // srst in the cycle after a read, while blinking
    bus_xfer(1'b1, 4'h4, 4'hF, 32'd2, rv, rd, w);
    m_prescale = 2;
    bus_xfer(1'b1, 4'h0, 4'hF, 32'h10F, rv, rd, w);
    m_led_val = 4'hF; m_blink_en = 1'b1; m_start = w; m_phase0 = 1'b1;
    for (int j = 0; j < 5; j++) begin
      bus_xfer(1'b0, 4'hC, 4'hF, 32'd0, rv, rd, w);
      checks++; if (led_o !== exp_led(w - 1)) begin errors++; $display("FAIL srst_pre_led: got %h expected %h", led_o, exp_led(w - 1)); end
    end
    bus_xfer(1'b0, 4'h0, 4'hF, 32'd0, rv, rd, w);
    checks++; if (rv !== 1'b1 || rd !== 32'h10F) begin errors++; $display("FAIL srst_pre_read: got %b/%h expected 1/0000010F", rv, rd); end
    srst = 1'b1;
    @(negedge clk);
    checks++; if (bus.rvalid_o !== 1'b0) begin errors++; $display("FAIL srst_rvalid: got %b expected 0", bus.rvalid_o); end
    checks++; if (led_o !== 4'h0) begin errors++; $display("FAIL srst_led: got %h expected 0", led_o); end
    srst = 1'b0;
    model_reset();
    bus_xfer(1'b0, 4'h4, 4'hF, 32'd0, rv, rd, w);
    checks++; if (rd !== 32'h004C4B3F) begin errors++; $display("FAIL srst_prescale: got %h expected 004C4B3F", rd); end
    bus_xfer(1'b0, 4'hC, 4'hF, 32'd0, rv, rd, w);
    checks++; if (rd !== exp_status(w - 1)) begin errors++; $display("FAIL srst_status: got %h expected %h", rd, exp_status(w - 1)); end
    @(negedge clk);
    checks++; if (led_o !== 4'h0) begin errors++; $display("FAIL srst_led_after: got %h expected 0", led_o); end
  endtask

  initial begin
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.addr_i  = 4'h0;
    bus.be_i    = 4'h0;
    bus.wdata_i = 32'd0;
    model_reset();
    test_reset();
    test_static();
    test_blink();
    test_pwm();
    test_back_to_back();
    test_byte_enable();
    test_srst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/led_pwm_ctrl.md
Name: led_pwm_ctrl

Overview:
Memory-mapped LED output controller that sits directly upstream of the top-level LED pins. It is a slave on the SoC data bus (ibex-style req/gnt/rvalid) and drives LED with a static pattern, optional blinking and 8-bit PWM dimming. It is the stage that produces the LED vector that top_fpga exports.

Parameters:
NUM_LED, 4, number of LED outputs (1..8)
PRESCALE_RST, 24'd4999999, reset value of the PRESCALE register (blink half-period minus 1, in clk cycles)

Ports:
clk  input  1  system clock
srst  input  1  synchronous reset, active-high
req_i  input  1  bus request
we_i  input  1  1 = write, 0 = read
addr_i  input  4  byte address within block; only bits [3:2] decoded
be_i  input  4  byte enables for writes
wdata_i  input  32  write data
gnt_o  output  1  grant, combinational, equal to req_i
rvalid_o  output  1  response valid, one cycle after an accepted request (reads and writes)
rdata_o  output  32  read data, valid with rvalid_o, 0 for writes
led_o  output  NUM_LED  LED drive, registered

Behaviour:
- Register map (word offsets):
  - 0x0 CTRL: [NUM_LED-1:0] led_val; [8] blink_en; other bits read 0.
  - 0x4 PRESCALE: [23:0] half-period minus 1.
  - 0x8 DUTY: [7:0] PWM duty.
  - 0xC STATUS (read-only): [0] blink phase; [15:8] pwm_cnt.
- Reset values: led_o=0, rvalid_o=0, rdata_o=0, led_val=0, blink_en=0, PRESCALE=PRESCALE_RST, DUTY=8'hFF, blink_cnt=0, phase=1, pwm_cnt=0.
- Bus timing:
  - Every req_i is accepted in the same cycle.
  - Writes update registers at the clock edge of acceptance. Byte lanes are gated by be_i.
  - rvalid_o pulses exactly one cycle later; rdata_o carries the register value sampled at acceptance.
  - Back-to-back requests are supported, giving one response per cycle.
  - Writes to STATUS are ignored. Byte enables of 0 change nothing but still produce rvalid_o.
- Blink engine:
  - If blink_en=0: blink_cnt is held at 0 and phase at 1.
  - If blink_en=1: blink_cnt increments each cycle. When blink_cnt==PRESCALE, blink_cnt returns to 0 and phase toggles. PRESCALE=0 therefore toggles every cycle.
  - Any write touching PRESCALE byte lanes clears blink_cnt to 0 in the same edge; phase is unchanged.
  - If PRESCALE is written to a value below the current blink_cnt, the clear above guarantees no wrap through 2^24.
  - Clearing blink_en forces phase to 1 on the next edge.
- PWM engine:
  - 8-bit pwm_cnt counts 0..254 and then wraps to 0, giving a period of 255 cycles.
  - pwm_on = (pwm_cnt < DUTY). DUTY=0 means always off; DUTY=255 means always on.
  - A DUTY write takes effect on the next comparison; there is no period-boundary synchronisation.
- Output: led_o <= led_val & {NUM_LED{phase}} & {NUM_LED{pwm_on}}. This adds one cycle of latency from any register or engine change to led_o.
- srst asserted mid-transaction: the pending rvalid_o is dropped (0 next cycle) and all state returns to reset values.

Test Plan:
- Reset, then write CTRL=0x5 with DUTY=0xFF and blink_en=0 -> led_o=4'b0101 two cycles after request; rvalid_o high one cycle after request, rdata_o=0.
- Read back CTRL, PRESCALE, DUTY after reset -> rdata_o = 0x0, 0x4C4B3F, 0xFF respectively, each with rvalid_o one cycle later.
- PRESCALE=3, CTRL=0x10F -> led_o alternates 4'hF/4'h0 every 4 cycles; STATUS[0] matches the phase.
- DUTY=64, CTRL=0x1, blink off -> led_o[0] high for exactly 64 of every 255 cycles; DUTY=0 -> never high.
- Write with be_i=4'b0010 to CTRL, wdata=0x0000_01FF -> only blink_en set, led_val unchanged; write to STATUS -> no state change.
- Assert srst for one cycle during blinking and in the cycle after a read request -> rvalid_o=0, led_o=0, and registers read back as their reset values.
